// File: rtl/register_bank.sv
// ----------------------------------------------------------------------------
// register_bank
//
// RV32I integer register file: 32 registers x 32 bits, one synchronous write
// port and two combinational read ports with write-through bypass. Register
// x0 is hardwired to zero.
//
// Ports:
//   clock       in   1   system clock, state updates on the rising edge
//   reset       in   1   synchronous active-high reset, clears every register
//   we          in   1   write enable
//   sel_in      in   5   write register index (rd)
//   sel_out_a   in   5   read port A index (rs1)
//   sel_out_b   in   5   read port B index (rs2)
//   data_in     in  32   write data
//   data_out_a  out 32   read port A data
//   data_out_b  out 32   read port B data
//
// Handshake: there is none. Reads are purely combinational and writes commit
// on every rising edge where we=1, reset=0 and sel_in is non-zero.
// ----------------------------------------------------------------------------
module register_bank (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  sel_in,
    input  logic [4:0]  sel_out_a,
    input  logic [4:0]  sel_out_b,
    input  logic [31:0] data_in,
    output logic [31:0] data_out_a,
    output logic [31:0] data_out_b
);

    // Entry 0 is only ever loaded with zero by reset; reads of x0 are
    // masked to zero regardless, so it never influences an output.
    logic [31:0] r_regs [0:31];

    // A write is live this cycle; also gates the bypass so that while reset
    // is asserted the outputs show stored (cleared) contents only.
    logic w_write_live;
    logic w_bypass_a;
    logic w_bypass_b;

    assign w_write_live = we && !reset && (sel_in != 5'd0);
    assign w_bypass_a   = w_write_live && (sel_in == sel_out_a);
    assign w_bypass_b   = w_write_live && (sel_in == sel_out_b);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_write_live) begin
            r_regs[sel_in] <= data_in;
        end
    end

    // Read mux: zero register first, then bypass, then storage. The bypass
    // keeps the value stable across the edge that commits the write.
    always_comb begin
        data_out_a = r_regs[sel_out_a];
        if (sel_out_a == 5'd0) begin
            data_out_a = 32'd0;
        end else if (w_bypass_a) begin
            data_out_a = data_in;
        end
    end

    always_comb begin
        data_out_b = r_regs[sel_out_b];
        if (sel_out_b == 5'd0) begin
            data_out_b = 32'd0;
        end else if (w_bypass_b) begin
            data_out_b = data_in;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// ----------------------------------------------------------------------------
// tb_register_bank
//
// Bench for register_bank. A driver applies one input vector per clock cycle
// just after the rising edge and pushes the expected {data_out_a, data_out_b}
// pair, computed from an array model of the register file, into exp_q. A
// monitor samples the outputs on the falling edge and compares them with the
// popped expectation. The model array is updated after each rising edge from
// the vector that was applied during that cycle.
// ----------------------------------------------------------------------------
module tb_register_bank;

    logic        clock;
    logic        reset;
    logic        we;
    logic [4:0]  sel_in;
    logic [4:0]  sel_out_a;
    logic [4:0]  sel_out_b;
    logic [31:0] data_in;
    logic [31:0] data_out_a;
    logic [31:0] data_out_b;

    register_bank dut (
        .clock      (clock),
        .reset      (reset),
        .we         (we),
        .sel_in     (sel_in),
        .sel_out_a  (sel_out_a),
        .sel_out_b  (sel_out_b),
        .data_in    (data_in),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [31:0] model_regs [0:31];
    logic [63:0] exp_q [$];
    logic        chk_pending;
    int          tests_run;
    int          tests_failed;

    // Value a read port must show for the current inputs.
    function automatic logic [31:0] ref_read(input logic [4:0] sel,
                                             input logic rst, input logic wen,
                                             input logic [4:0] wsel,
                                             input logic [31:0] din);
        if (sel == 5'd0) return 32'd0;
        if (wen && !rst && wsel == sel) return din;
        return model_regs[sel];
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic rst, input logic wen, input logic [4:0] si,
                        input logic [4:0] sa, input logic [4:0] sb,
                        input logic [31:0] din);
        logic [31:0] ea;
        logic [31:0] eb;
        reset     = rst;
        we        = wen;
        sel_in    = si;
        sel_out_a = sa;
        sel_out_b = sb;
        data_in   = din;
        ea = ref_read(sa, rst, wen, si, din);
        eb = ref_read(sb, rst, wen, si, din);
        exp_q.push_back({ea, eb});
        chk_pending = 1'b1;
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        end else if (wen && si != 5'd0) begin
            model_regs[si] = din;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rand_sel(input logic [4:0] wsel);
        case ($urandom_range(0, 7))
            0:       return 5'd0;
            1:       return 5'd31;
            2, 3:    return wsel;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (chk_pending) begin
            logic [63:0] exp;
            chk_pending = 1'b0;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL scoreboard_empty: output sampled with no expectation queued");
            end else begin
                exp = exp_q.pop_front();
                tests_run++;
                if (data_out_a !== exp[63:32]) begin
                    tests_failed++;
                    $display("FAIL port_a t=%0t sel_a=%0d we=%0b rst=%0b sel_in=%0d: got %h expected %h",
                             $time, sel_out_a, we, reset, sel_in, data_out_a, exp[63:32]);
                end
                tests_run++;
                if (data_out_b !== exp[31:0]) begin
                    tests_failed++;
                    $display("FAIL port_b t=%0t sel_b=%0d we=%0b rst=%0b sel_in=%0d: got %h expected %h",
                             $time, sel_out_b, we, reset, sel_in, data_out_b, exp[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] si;
        tests_run    = 0;
        tests_failed = 0;
        chk_pending  = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        reset = 1'b1; we = 1'b0; sel_in = '0; sel_out_a = '0; sel_out_b = '0; data_in = '0;
        @(posedge clock);
        #1;

        // Reset and zero-select state
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 31, 0);
        // x0 protection, before and after the edge
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // Write x1 and port independence
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 1, 0, 1);
        step(0, 1, 1, 1, 1, 1);
        // Hold with changing data_in
        step(0, 0, 1, 1, 1, 3);
        step(0, 0, 1, 1, 1, 7);
        step(0, 0, 1, 1, 1, 3);
        step(0, 0, 1, 1, 1, 7);
        // Top register with bypass, then storage
        step(0, 1, 31, 31, 1, 7);
        step(0, 1, 31, 31, 1, 7);
        step(0, 0, 31, 31, 1, 7);
        // Reset priority over a simultaneous write
        step(1, 1, 5, 5, 31, 9);
        step(0, 0, 5, 1, 31, 0);
        step(0, 0, 5, 5, 5, 0);
        step(0, 0, 5, 31, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            si = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), si,
                 rand_sel(si), rand_sel(si), rand_data());
        end
        we = 1'b0;
        reset = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && (exp_q.size() != 0 || chk_pending); k++) @(posedge clock);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
